// File: rtl/pattern_serializer_pkg.sv
// Shared types and constants for the pattern serializer and its bit-serial neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_serializer_pkg;

   // One-hot FSM encoding, same style as the downstream pattern detectors.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b01,
      ST_SHIFT = 2'b10
   } ser_state_t;

   localparam int DEF_WIDTH = 8;

   // Bit-counter width needed to count 0..w-1.
   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

   localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/pattern_serializer_hold_buf.sv
// One-entry holding register that parks the next word while the current one shifts out.
// Latency: 1 cycle from write to hold_full.
// Backpressure: producer must not write while hold_full (in_ready is derived from it).
module pattern_hold_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic             hold_full,
   output logic [WIDTH-1:0] hold_data
);

   // Write sets the entry, read clears it; the two never coincide because
   // writes are only accepted while the entry is empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (wr_en) begin
         hold_full <= 1'b1;
         hold_data <= wr_data;
      end else if (rd_en) begin
         hold_full <= 1'b0;
      end
   end

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in on valid/ready, one bit per ser_en cycle out.
// Latency: first bit on data_out one cycle after accept; back-to-back words are gapless.
// Backpressure: in_ready = !hold_full (registered only); ser_en=0 freezes the serial outputs.
module pattern_serializer
   import pattern_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ser_en,
   output logic             data_out,
   output logic             data_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shift_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic             dout_q;
   logic             dvld_q;

   logic             hold_full;
   logic [WIDTH-1:0] hold_data;

   logic             accept;
   logic             at_last;
   logic             adv;
   logic             last_adv;
   logic             load_direct;
   logic             load_hold;
   logic             hold_wr;
   logic [WIDTH-1:0] load_word;

   // Bit that goes out first for a given word, per the elaborated bit order.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Drop the bit just emitted so the next one sits at the output end.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   pattern_hold_buf #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en     (hold_wr),
      .wr_data   (in_data),
      .rd_en     (load_hold),
      .hold_full (hold_full),
      .hold_data (hold_data)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and steering: where an accepted word goes and when the hold drains.
   always_comb begin
      state_d     = state_q;
      accept      = in_valid & ~hold_full;
      at_last     = (bit_cnt_q == CNT_LAST);
      adv         = (state_q == ST_SHIFT) & ser_en & dvld_q;
      last_adv    = adv & at_last;
      load_direct = 1'b0;
      load_hold   = 1'b0;
      hold_wr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               load_direct = 1'b1;
               state_d     = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_adv) begin
               // hold_full blocks accept, so at most one of these applies.
               if (hold_full)   load_hold   = 1'b1;
               else if (accept) load_direct = 1'b1;
               else             state_d     = ST_IDLE;
            end else if (accept) begin
               hold_wr = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign load_word = load_hold ? hold_data : in_data;

   // Shift register, bit counter and registered serial outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         dout_q    <= 1'b0;
         dvld_q    <= 1'b0;
      end else if (load_direct | load_hold) begin
         shift_q   <= shift_once(load_word);
         bit_cnt_q <= '0;
         dout_q    <= first_bit(load_word);
         dvld_q    <= 1'b1;
      end else if (last_adv) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         dout_q    <= 1'b0;
         dvld_q    <= 1'b0;
      end else if (adv) begin
         shift_q   <= shift_once(shift_q);
         bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         dout_q    <= first_bit(shift_q);
      end
   end

   assign in_ready   = ~hold_full;
   assign data_out   = dout_q;
   assign data_valid = dvld_q;
   assign last_bit   = at_last & dvld_q;
   assign busy       = (state_q == ST_SHIFT) | hold_full;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: queue model of the expected bit stream plus directed word tests.
// Latency: n/a.
// Backpressure: n/a.
module tb_pattern_serializer;

   localparam int W = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // Instance A: MSB first.
   logic [W-1:0] a_in_data  = '0;
   logic         a_in_valid = 1'b0;
   logic         a_ser_en   = 1'b1;
   logic         a_in_ready, a_data_out, a_data_valid, a_last_bit, a_busy;

   // Instance B: LSB first.
   logic [W-1:0] b_in_data  = '0;
   logic         b_in_valid = 1'b0;
   logic         b_ser_en   = 1'b1;
   logic         b_in_ready, b_data_out, b_data_valid, b_last_bit, b_busy;

   pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rstn(rstn), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .ser_en(a_ser_en), .data_out(a_data_out), .data_valid(a_data_valid),
      .last_bit(a_last_bit), .busy(a_busy));

   pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rstn(rstn), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .ser_en(b_ser_en), .data_out(b_data_out), .data_valid(b_data_valid),
      .last_bit(b_last_bit), .busy(b_busy));

   int nvec  = 0;
   int nfail = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model for A: the stream still owed downstream, one entry {bit, is_last} per bit.
   // Bits currently buffered (shifting word + held word) are all in the queue, so
   // valid/busy follow "anything owed" and the hold is full when more than one word is owed.
   logic [1:0] q[$];
   bit         acc_m;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q.delete();
      end else begin
         acc_m = a_in_valid && (q.size() <= W);
         if (a_ser_en && q.size() != 0) void'(q.pop_front());
         if (acc_m)
            for (int i = 0; i < W; i++)
               q.push_back({a_in_data[W-1-i], (i == W-1) ? 1'b1 : 1'b0});
      end
   end

   // Per-cycle comparison of A against the model.
   always @(negedge clk) begin
      if (rstn) begin
         chk1("data_valid", a_data_valid, q.size() != 0);
         chk1("busy", a_busy, q.size() != 0);
         chk1("in_ready", a_in_ready, q.size() <= W);
         if (q.size() != 0) begin
            chk1("data_out", a_data_out, q[0][1]);
            chk1("last_bit", a_last_bit, q[0][0]);
         end else begin
            chk1("data_out_idle", a_data_out, 1'b0);
            chk1("last_bit_idle", a_last_bit, 1'b0);
         end
      end
   end

   // Observer on A: consumed bits, valid cycles, and a behavioural 101 detector on data_out.
   logic [63:0] col_bits  = '0;
   int          consumed  = 0;
   int          dv_cyc    = 0;
   int          last_cnt  = 0;
   int          match_cnt = 0;
   logic [2:0]  win       = '0;
   int          win_n     = 0;
   always @(negedge clk) begin
      if (!rstn) begin
         win   = '0;
         win_n = 0;
      end else if (a_data_valid) begin
         dv_cyc++;
         if (a_ser_en) begin
            col_bits = {col_bits[62:0], a_data_out};
            consumed++;
            if (a_last_bit) last_cnt++;
            win = {win[1:0], a_data_out};
            if (win_n < 3) win_n++;
            if (win_n == 3 && win == 3'b101) match_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [W-1:0] w);
      int t = 0;
      while (!a_in_ready && t < 100) begin
         tick();
         t++;
      end
      chk1("send_a ready timeout", a_in_ready, 1'b1);
      a_in_data  = w;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
   endtask

   task automatic wait_idle_a();
      int t = 0;
      while (a_busy && t < 200) begin
         tick();
         t++;
      end
      chk1("idle timeout", a_busy, 1'b0);
   endtask

   int          c0, d0, l0, m0;
   logic [W-1:0] seq;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      #2;
      chk1("rst data_valid", a_data_valid, 1'b0);
      chk1("rst data_out", a_data_out, 1'b0);
      chk1("rst last_bit", a_last_bit, 1'b0);
      chk1("rst busy", a_busy, 1'b0);
      chk1("rst in_ready", a_in_ready, 1'b1);
      tick();
      tick();
      rstn = 1'b1;
      tick();

      // 1: single word, free-running ser_en.
      c0 = consumed; d0 = dv_cyc; l0 = last_cnt;
      send_a(8'hA5);
      wait_idle_a();
      chkw("t1 bits consumed", 64'(consumed - c0), 64'd8);
      chkw("t1 bit stream", 64'(col_bits[7:0]), 64'hA5);
      chkw("t1 valid cycles", 64'(dv_cyc - d0), 64'd8);
      chkw("t1 last_bit count", 64'(last_cnt - l0), 64'd1);
      chk1("t1 busy after", a_busy, 1'b0);

      // 2: back-to-back words through the hold buffer.
      c0 = consumed; d0 = dv_cyc; l0 = last_cnt;
      send_a(8'hA5);
      send_a(8'h5A);
      chk1("t2 in_ready with hold full", a_in_ready, 1'b0);
      wait_idle_a();
      chkw("t2 bits consumed", 64'(consumed - c0), 64'd16);
      chkw("t2 bit stream", 64'(col_bits[15:0]), 64'hA55A);
      chkw("t2 valid cycles gapless", 64'(dv_cyc - d0), 64'd16);
      chkw("t2 last_bit count", 64'(last_cnt - l0), 64'd2);

      // 3: stall three cycles while bit index 2 of F0 is on the output.
      c0 = consumed; d0 = dv_cyc;
      send_a(8'hF0);
      tick();
      tick();
      a_ser_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("t3 stalled data_out", a_data_out, 1'b1);
         chk1("t3 stalled last_bit", a_last_bit, 1'b0);
      end
      a_ser_en = 1'b1;
      wait_idle_a();
      chkw("t3 bits consumed", 64'(consumed - c0), 64'd8);
      chkw("t3 bit stream", 64'(col_bits[7:0]), 64'hF0);
      chkw("t3 valid cycles", 64'(dv_cyc - d0), 64'd11);

      // 4: asynchronous reset mid-word with the hold buffer full.
      send_a(8'hFF);
      send_a(8'hFF);
      tick();
      tick();
      #2;
      rstn = 1'b0;
      #1;
      chk1("t4 data_valid", a_data_valid, 1'b0);
      chk1("t4 data_out", a_data_out, 1'b0);
      chk1("t4 last_bit", a_last_bit, 1'b0);
      chk1("t4 busy", a_busy, 1'b0);
      chk1("t4 in_ready", a_in_ready, 1'b1);
      tick();
      rstn = 1'b1;
      d0 = dv_cyc;
      for (int i = 0; i < 20; i++) tick();
      chkw("t4 residual valid cycles", 64'(dv_cyc - d0), 64'd0);

      // 5: LSB-first instance, 8'h01 -> 1 then seven 0s.
      b_in_data  = 8'h01;
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      seq = '0;
      for (int i = 0; i < W; i++) begin
         chk1("t5 data_valid", b_data_valid, 1'b1);
         chk1("t5 last_bit", b_last_bit, (i == W-1) ? 1'b1 : 1'b0);
         seq[i] = b_data_out;
         tick();
      end
      chk1("t5 data_valid after", b_data_valid, 1'b0);
      chkw("t5 bit order", 64'(seq), 64'h01);

      // 6: cascade into the 101 detector after a clean reset.
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
      m0 = match_cnt; c0 = consumed;
      send_a(8'b0010_1010);
      wait_idle_a();
      chkw("t6 bit stream", 64'(col_bits[7:0]), 64'h2A);
      chkw("t6 detector matches", 64'(match_cnt - m0), 64'd2);
      chkw("t6 bits consumed", 64'(consumed - c0), 64'd8);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
